// File: rtl/fetch_decode_execute_pkg.sv
// rtl/fetch_decode_execute_pkg.sv - shared types, opcodes and decode table for the 3-stage core
package fetch_decode_execute_pkg;

  typedef logic [15:0] block_t;
  typedef logic [7:0]  addr_t;
  typedef logic [15:0] inst_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_GT   = 4'h5;
  localparam logic [3:0] OP_EQ   = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam inst_t NOP_INST = 16'h0000;

  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_and;
    logic is_or;
    logic is_gt;
    logic is_eq;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic halt;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [3:0]  rd;
    block_t      val1;
    block_t      val2;
    block_t      val3;
    logic [7:0]  imm;
  } de_t;

  localparam de_t DE_NOP = '0;

  // JMP is absent: it is fully resolved in Decode and never reaches Execute.
  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.is_add = 1'b1; c.reg_write = 1'b1; end
      OP_SUB:  begin c.is_sub = 1'b1; c.reg_write = 1'b1; end
      OP_AND:  begin c.is_and = 1'b1; c.reg_write = 1'b1; end
      OP_OR:   begin c.is_or  = 1'b1; c.reg_write = 1'b1; end
      OP_GT:   begin c.is_gt  = 1'b1; c.reg_write = 1'b1; end
      OP_EQ:   begin c.is_eq  = 1'b1; c.reg_write = 1'b1; end
      OP_LDI:  c.reg_write = 1'b1;
      OP_LD:   begin c.mem_read = 1'b1; c.reg_write = 1'b1; end
      OP_ST:   c.mem_write = 1'b1;
      OP_BNZ:  c.branch = 1'b1;
      OP_HALT: c.halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_decode_execute_if.sv
// rtl/fetch_decode_execute_if.sv - instruction and data memory bus between core and memories
interface fetch_decode_execute_if;
  import fetch_decode_execute_pkg::*;

  addr_t  imem_addr;
  inst_t  imem_data;
  addr_t  dmem_addr;
  block_t dmem_wdata;
  logic   dmem_we;
  block_t dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    output dmem_rdata
  );
endinterface

// File: rtl/fetch_decode_execute_regfile.sv
// rtl/fetch_decode_execute_regfile.sv - 16x16 register file, two read ports, debug port, r0 hardwired to 0
module fetch_decode_execute_regfile
  import fetch_decode_execute_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  block_t     wdata,
  input  logic [3:0] ra_addr,
  output block_t     ra_data,
  input  logic [3:0] rb_addr,
  output block_t     rb_data,
  input  logic [3:0] dbg_sel,
  output block_t     dbg_data
);

  block_t regs [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && waddr != 4'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = (ra_addr == 4'd0) ? '0 : regs[ra_addr];
  assign rb_data  = (rb_addr == 4'd0) ? '0 : regs[rb_addr];
  assign dbg_data = (dbg_sel == 4'd0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/fetch_decode_execute.sv
// rtl/fetch_decode_execute.sv - in-order Fetch/Decode/Execute datapath with E->D forwarding and sticky halt
module fetch_decode_execute
  import fetch_decode_execute_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  fetch_decode_execute_if.master  bus,
  output logic                    do_halt,
  input  logic [3:0]              dbg_sel,
  output block_t                  dbg_data
);

  addr_t  pc;
  inst_t  fd_inst;
  de_t    de;

  logic [3:0] d_op, d_rd, d_rs, d_rt, rb_sel;
  logic       d_jump, d_uses_rd, ex_fwd, ex_taken;
  block_t     ra_data, rb_data, d_val1, d_valb, ex_result;
  de_t        d_next;

  assign d_op      = fd_inst[15:12];
  assign d_rd      = fd_inst[11:8];
  assign d_rs      = fd_inst[7:4];
  assign d_rt      = fd_inst[3:0];
  assign d_jump    = (d_op == OP_JMP);
  // ST and BNZ consume rd instead of rt, so the second read port is steered to it.
  assign d_uses_rd = (d_op == OP_ST) || (d_op == OP_BNZ);
  assign rb_sel    = d_uses_rd ? d_rd : d_rt;

  fetch_decode_execute_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (de.ctrl.reg_write && !do_halt),
    .waddr    (de.rd),
    .wdata    (ex_result),
    .ra_addr  (d_rs),
    .ra_data  (ra_data),
    .rb_addr  (rb_sel),
    .rb_data  (rb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign ex_fwd = de.ctrl.reg_write && (de.rd != 4'd0);
  assign d_val1 = (ex_fwd && de.rd == d_rs)   ? ex_result : ra_data;
  assign d_valb = (ex_fwd && de.rd == rb_sel) ? ex_result : rb_data;

  always_comb begin
    d_next      = DE_NOP;
    d_next.ctrl = decode_op(d_op);
    d_next.rd   = d_rd;
    d_next.val1 = d_val1;
    d_next.val2 = d_uses_rd ? '0 : d_valb;
    d_next.val3 = d_uses_rd ? d_valb : '0;
    d_next.imm  = fd_inst[7:0];
  end

  // LDI is the fall-through result when no ALU or load bit is set.
  always_comb begin
    ex_result = {8'h00, de.imm};
    if (de.ctrl.is_add)        ex_result = de.val1 + de.val2;
    else if (de.ctrl.is_sub)   ex_result = de.val1 - de.val2;
    else if (de.ctrl.is_and)   ex_result = de.val1 & de.val2;
    else if (de.ctrl.is_or)    ex_result = de.val1 | de.val2;
    else if (de.ctrl.is_gt)    ex_result = (de.val1 > de.val2) ? 16'd1 : 16'd0;
    else if (de.ctrl.is_eq)    ex_result = (de.val1 == de.val2) ? 16'd1 : 16'd0;
    else if (de.ctrl.mem_read) ex_result = bus.dmem_rdata;
  end

  assign ex_taken       = de.ctrl.branch && (de.val3 != '0);
  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = (de.ctrl.mem_read || de.ctrl.mem_write) ? de.val1[7:0] : '0;
  assign bus.dmem_wdata = de.ctrl.mem_write ? de.val3 : '0;
  assign bus.dmem_we    = de.ctrl.mem_write && !do_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      fd_inst <= NOP_INST;
      de      <= DE_NOP;
      do_halt <= 1'b0;
    end else if (!do_halt) begin
      if (de.ctrl.halt) begin
        do_halt <= 1'b1;
        fd_inst <= NOP_INST;
        de      <= DE_NOP;
      end else if (ex_taken) begin
        pc      <= de.imm;
        fd_inst <= NOP_INST;
        de      <= DE_NOP;
      end else begin
        de <= d_next;
        if (d_jump) begin
          pc      <= fd_inst[7:0];
          fd_inst <= NOP_INST;
        end else begin
          pc      <= pc + 8'd1;
          fd_inst <= bus.imem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// tb/tb_fetch_decode_execute.sv - directed and random programs checked against an instruction-level model
module tb_fetch_decode_execute;
  import fetch_decode_execute_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       do_halt;
  logic [3:0] dbg_sel = 4'd0;
  block_t     dbg_data;

  fetch_decode_execute_if bus ();

  fetch_decode_execute dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .do_halt  (do_halt),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  logic [15:0] imem    [256];
  logic [15:0] dmem    [256];
  logic [15:0] dm_init [256];
  logic        dm_load = 1'b0;
  int          st_count;

  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clk) begin
    if (dm_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dm_init[i];
      st_count <= 0;
    end else if (bus.dmem_we) begin
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
      st_count <= st_count + 1;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      imem[i]    = 16'h0000;
      dm_init[i] = 16'($urandom);
    end
  endtask

  // Architectural reference: one instruction per step; cycle count adds fetch slots lost to redirects.
  logic [15:0] m_regs [16];
  logic [15:0] m_dm   [256];
  int          m_halt_cyc;
  int          m_stores;
  logic [7:0]  m_halt_pc;

  task automatic run_model();
    logic [7:0]  pc;
    logic [15:0] ins, a, b, d, res;
    logic [3:0]  op, rd;
    logic        wr, done;
    int          cyc;
    pc = 8'd0; cyc = 0; m_stores = 0; done = 1'b0;
    m_halt_cyc = -100; m_halt_pc = 8'd0;
    for (int i = 0; i < 16; i++)  m_regs[i] = 16'h0;
    for (int i = 0; i < 256; i++) m_dm[i] = dm_init[i];
    for (int step = 0; step < 1000 && !done; step++) begin
      ins = imem[pc];
      op  = ins[15:12];
      rd  = ins[11:8];
      a   = m_regs[ins[7:4]];
      b   = m_regs[ins[3:0]];
      d   = m_regs[rd];
      wr  = 1'b1;
      res = 16'h0;
      case (op)
        4'h1: res = a + b;
        4'h2: res = a - b;
        4'h3: res = a & b;
        4'h4: res = a | b;
        4'h5: res = (a > b) ? 16'd1 : 16'd0;
        4'h6: res = (a == b) ? 16'd1 : 16'd0;
        4'h7: res = {8'h00, ins[7:0]};
        4'h8: res = m_dm[a[7:0]];
        default: wr = 1'b0;
      endcase
      if (wr && rd != 4'd0) m_regs[rd] = res;
      if (op == 4'h9) begin
        m_dm[a[7:0]] = d;
        m_stores++;
      end
      if (op == 4'hF) begin
        m_halt_cyc = cyc;
        m_halt_pc  = pc + 8'd2;
        done       = 1'b1;
      end else if (op == 4'hB) begin
        pc = ins[7:0]; cyc += 2;
      end else if (op == 4'hA && d != 16'h0) begin
        pc = ins[7:0]; cyc += 3;
      end else begin
        pc = pc + 8'd1; cyc += 1;
      end
    end
  endtask

  task automatic run_case(input string name);
    int edges;
    logic [7:0] pc_frz;
    run_model();
    rst = 1'b1;
    dm_load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dm_load = 1'b0;
    chk({name, ":rst_halt"}, 32'(do_halt), 32'd0);
    chk({name, ":rst_pc"}, 32'(bus.imem_addr), 32'd0);
    chk({name, ":rst_we"}, 32'(bus.dmem_we), 32'd0);
    chk({name, ":rst_daddr"}, 32'(bus.dmem_addr), 32'd0);
    chk({name, ":rst_wdata"}, 32'(bus.dmem_wdata), 32'd0);
    rst = 1'b0;
    edges = 0;
    while (do_halt !== 1'b1 && edges < 3000) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk({name, ":halt_cycle"}, 32'(edges), 32'(m_halt_cyc + 3));
    chk({name, ":halt_pc"}, 32'(bus.imem_addr), 32'(m_halt_pc));
    pc_frz = bus.imem_addr;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({name, ":frozen_pc"}, 32'(bus.imem_addr), 32'(pc_frz));
      chk({name, ":frozen_we"}, 32'(bus.dmem_we), 32'd0);
    end
    chk({name, ":stores"}, 32'(st_count), 32'(m_stores));
    for (int r = 0; r < 16; r++) begin
      dbg_sel = 4'(r);
      #1;
      chk($sformatf("%s:r%0d", name, r), 32'(dbg_data), 32'(m_regs[r]));
    end
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s:dmem%0h", name, i), 32'(dmem[i]), 32'(m_dm[i]));
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [15:0] exp);
    dbg_sel = 4'(r);
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int n, op, sel;

    clear_prog();
    imem[0] = enc_i(4'h7, 4'd1, 8'd5);
    imem[1] = enc_i(4'h7, 4'd2, 8'd3);
    imem[2] = enc(4'h1, 4'd3, 4'd1, 4'd2);
    imem[3] = enc(4'h2, 4'd4, 4'd1, 4'd2);
    imem[4] = enc(4'h5, 4'd5, 4'd1, 4'd2);
    imem[5] = enc(4'h6, 4'd6, 4'd1, 4'd2);
    imem[6] = 16'hF000;
    run_case("alu");
    chk_reg("alu_add_r3", 3, 16'd8);
    chk_reg("alu_sub_r4", 4, 16'd2);
    chk_reg("alu_gt_r5", 5, 16'd1);
    chk_reg("alu_eq_r6", 6, 16'd0);

    clear_prog();
    imem[0] = enc_i(4'h7, 4'd1, 8'h20);
    imem[1] = enc_i(4'h7, 4'd2, 8'hAB);
    imem[2] = enc(4'h9, 4'd2, 4'd1, 4'd0);
    imem[3] = enc(4'h8, 4'd3, 4'd1, 4'd0);
    imem[4] = enc(4'h1, 4'd4, 4'd3, 4'd3);
    imem[5] = 16'hF000;
    run_case("mem");
    chk("mem_dmem20", 32'(dmem[8'h20]), 32'h00AB);
    chk_reg("mem_ld_r3", 3, 16'h00AB);
    chk_reg("mem_fwd_r4", 4, 16'h0156);

    clear_prog();
    imem[0]     = enc_i(4'h7, 4'd1, 8'd1);
    imem[1]     = enc_i(4'hA, 4'd1, 8'h10);
    imem[2]     = enc_i(4'h7, 4'd2, 8'd7);
    imem[3]     = enc_i(4'h7, 4'd3, 8'd7);
    imem[8'h10] = enc_i(4'h7, 4'd4, 8'd4);
    imem[8'h11] = 16'hF000;
    run_case("bnz_taken");
    chk_reg("bnz_sq_r2", 2, 16'd0);
    chk_reg("bnz_tgt_r4", 4, 16'd4);

    clear_prog();
    imem[0] = enc_i(4'hA, 4'd2, 8'h10);
    imem[1] = enc_i(4'h7, 4'd3, 8'd3);
    imem[2] = 16'hF000;
    run_case("bnz_fall");
    chk_reg("bnz_fall_r3", 3, 16'd3);

    clear_prog();
    imem[0] = enc_i(4'hB, 4'd0, 8'h08);
    imem[1] = enc_i(4'h7, 4'd1, 8'd9);
    imem[8] = enc_i(4'h7, 4'd2, 8'd2);
    imem[9] = 16'hF000;
    run_case("jmp");
    chk_reg("jmp_sq_r1", 1, 16'd0);

    clear_prog();
    imem[0] = 16'hF000;
    imem[1] = enc_i(4'h7, 4'd1, 8'd7);
    run_case("halt");
    chk_reg("halt_r1", 1, 16'd0);

    clear_prog();
    imem[0] = enc_i(4'h7, 4'd0, 8'hFF);
    imem[1] = enc(4'h1, 4'd1, 4'd0, 4'd0);
    imem[2] = 16'hF000;
    run_case("r0");
    chk_reg("r0_dbg0", 0, 16'd0);
    chk_reg("r0_r1", 1, 16'd0);

    for (int t = 0; t < 20; t++) begin
      clear_prog();
      n = $urandom_range(40, 6);
      for (int pc = 0; pc < n - 1; pc++) begin
        op = $urandom_range(14, 0);
        sel = $urandom_range(3, 0);
        if (op == 10 || op == 11)
          imem[pc] = enc_i(4'(op), 4'($urandom_range(5, 0)), 8'($urandom_range(n - 1, pc + 1)));
        else if (op == 7 || sel == 0)
          imem[pc] = enc_i(4'(op), 4'($urandom_range(5, 0)), 8'($urandom));
        else
          imem[pc] = enc(4'(op), 4'($urandom_range(5, 0)), 4'($urandom_range(5, 0)),
                         4'($urandom_range(5, 0)));
      end
      imem[n - 1] = 16'hF000;
      run_case($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_execute.md
# fetch_decode_execute

Three-stage in-order core datapath (Fetch → Decode → Execute) between the PC/instruction memory and the data memory of the CPU top level. It fetches 16-bit instructions and decodes them into ALU/memory/branch controls, and it reads a 16×16 register file with single-path forwarding. It executes ALU, load/store, branch, jump and halt operations, and raises a sticky halt flag that the top level uses to gate its clock.

## Interface
- No parameters. Widths are fixed by shared types: block = 16 bits, addr = 8 bits, inst = 16 bits.
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- imem_addr  out  8  fetch address, equal to the PC
- imem_data  in  16  instruction at imem_addr; combinational, valid in the same cycle
- dmem_addr  out  8  data address
- dmem_wdata  out  16  store data
- dmem_we  out  1  store strobe; memory writes on the clk edge
- dmem_rdata  in  16  combinational read of dmem_addr
- do_halt  out  1  sticky; high once HALT executes
- dbg_sel  in  4  register-file debug select
- dbg_data  out  16  combinational value of register dbg_sel (r0 reads 0)

## Operation
Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0]; imm8 = inst[7:0].

Opcodes:
- 0 NOP.
- 1 ADD rd=rs+rt.
- 2 SUB rd=rs−rt.
- 3 AND.
- 4 OR.
- 5 GT: rd=(rs>rt, unsigned)?1:0.
- 6 EQ: rd=(rs==rt)?1:0.
- 7 LDI: rd={8'h00,imm8}.
- 8 LD: rd=dmem[rs[7:0]].
- 9 ST: dmem[rs[7:0]]=rd.
- A BNZ: if rd≠0 then PC=imm8.
- B JMP: PC=imm8.
- F HALT.
- C, D, E execute as NOP.

Arithmetic:
- Wraps modulo 2^16.
- PC increments modulo 2^8 (255→0).

Register file:
- r0 always reads 0; writes to r0 are discarded.
- All registers clear to 0 on reset.

Stages:
- Fetch: registers {imem_data, pc} into F/D.
- Decode: produces is_add/sub/and/or/gt/eq/mem_read/mem_write/reg_write/branch/jump/halt plus val1 (rs), val2 (rt), val3 (rd). It resolves JMP.
- Execute: computes the result and drives dmem. It writes rd at the end of the cycle and resolves BNZ and HALT.

Hazards:
- Forwarding: if E has reg_write with target ≠0 matching a D source (rs, rt or rd), D takes E's result. This includes load data from dmem_rdata. No stall is ever required.
- JMP in D: F/D becomes NOP and PC←imm8 next edge. Penalty is 1 cycle.
- Taken BNZ in E: F/D and D/E become NOP and PC←imm8. Penalty is 2 cycles. Not-taken BNZ has no penalty.
- Simultaneous JMP in D and taken BNZ in E: the branch wins and the JMP is squashed.

HALT:
- On reaching E, do_halt←1 and younger instructions are squashed.
- PC, pipeline registers, register file and memory strobes freeze (dmem_we=0) until rst.

## Timing
- Reset (synchronous): PC=0, F/D=NOP, D/E=NOP, registers=0, do_halt=0, dmem_we=0. dmem_addr and dmem_wdata are 0 while E holds NOP.
- First edge after rst deasserts: fetches address 0.
- Instruction at address n with no redirects: in F during cycle n, D during n+1, E during n+2. Its register write or store commits on the edge ending cycle n+2.
- A dependent instruction immediately following sees the new value via forwarding.
- rst asserted mid-operation: all state returns to reset values on the next edge, including clearing do_halt. Any in-flight store is dropped unless already committed.
- dmem_we is high only in the E cycle of ST and only while do_halt=0.

## Structure
- Shared package holds the block/addr/inst typedefs, opcode constants, and a NOP instruction constant (16'h0000).
- One sub-module: regfile (2 combinational read ports plus debug port, 1 write port, r0 zero).
- Fetch, Decode and Execute stay as stage logic within this block. Decode control bits are carried in a packed struct in D/E.

## Test plan
- LDI r1,5; LDI r2,3; ADD r3,r1,r2; SUB r4,r1,r2 (back-to-back, forwarded) → r3=8, r4=2. GT r5,r1,r2 → 1; EQ r6,r1,r2 → 0.
- LDI r1,0x20; LDI r2,0xAB; ST r2,[r1]; LD r3,[r1]; ADD r4,r3,r3 → dmem[0x20]=0x00AB, r3=0x00AB, r4=0x0156.
- BNZ with rd=1 to 0x10 → the two following instructions do not write, and execution resumes at 0x10. Repeat with rd=0 → falls through with no bubble.
- JMP 0x08 followed by LDI r1,9 → r1 stays 0. Instruction at 0x08 executes after 1 bubble.
- HALT followed by LDI r1,7 → do_halt=1 three cycles after HALT is fetched; r1=0; PC frozen; dmem_we=0 thereafter. Pulse rst → do_halt=0 and PC=0.
- Write r0 via LDI r0,0xFF, then ADD r1,r0,r0 → r1=0, and dbg_data for dbg_sel=0 is 0.
